// File: rtl/xc_rf_writeback_if.sv
// Result request bus from the execute stage into the regfile write front end.
//   req_valid    : producer has a result this cycle
//   req_ready    : consumer can take a result this cycle
//   req_wide     : 1 = 64-bit register-pair result, 0 = single 32-bit result
//   req_rd       : destination register (bit 0 ignored for pair results)
//   req_wdata_lo : narrow data, or data for the even register of a pair
//   req_wdata_hi : data for the odd register of a pair
// master = execute stage (producer), slave = write-back front end (consumer).
interface xc_rf_writeback_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wide;
  logic [4:0]  req_rd;
  logic [31:0] req_wdata_lo;
  logic [31:0] req_wdata_hi;

  modport master (
    output req_valid, req_wide, req_rd, req_wdata_lo, req_wdata_hi,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_wide, req_rd, req_wdata_lo, req_wdata_hi,
    output req_ready
  );
endinterface

// File: rtl/xc_rf_writeback.sv
// Write-side front end of the 3-read/1-write GPR file.
// Buffers narrow (32-bit) and wide (register-pair) results in a DEPTH-entry
// FIFO and serialises them onto the single regfile write port, one register
// per cycle. Also flags, per read port, whether a buffered write to the
// addressed register is still pending.
// Ports:
//   clock, reset       : clock, synchronous active-high reset
//   req (slave)        : result request bus (valid/ready)
//   rd_wen/addr/wdata  : regfile write port (combinational from FIFO head)
//   rs1..3_addr        : read-port addresses to test for pending writes
//   rs1..3_busy        : a buffered write to that address is still pending
//   idle               : FIFO empty, no beat in progress
module xc_rf_writeback #(
  parameter int DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset,
  xc_rf_writeback_if.slave  req,
  output logic              rd_wen,
  output logic [4:0]        rd_addr,
  output logic [31:0]       rd_wdata,
  input  logic [4:0]        rs1_addr,
  input  logic [4:0]        rs2_addr,
  input  logic [4:0]        rs3_addr,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              rs3_busy,
  output logic              idle
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic {BEAT_LO, BEAT_HI} beat_t;

  beat_t              state_reg, state_next;
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]   count_reg;

  logic               wide_mem [DEPTH];
  logic [4:0]         rd_mem   [DEPTH];
  logic [31:0]        lo_mem   [DEPTH];
  logic [31:0]        hi_mem   [DEPTH];

  logic               head_valid;
  logic               full;
  logic               push;
  logic               pop;
  logic               head_wide;
  logic [4:0]         head_rd;
  logic [4:0]         beat_addr;
  logic [31:0]        beat_data;

  assign head_valid = (count_reg != '0);
  assign full       = (count_reg == CNT_W'(DEPTH));
  // No bypass: a pop in the same cycle does not make room for a push.
  assign push       = req.req_valid && !full && !reset;
  assign head_wide  = wide_mem[rd_ptr_reg];
  assign head_rd    = rd_mem[rd_ptr_reg];

  // Beat FSM: next state, pop and the beat presented on the write port.
  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    beat_addr  = 5'd0;
    beat_data  = 32'd0;
    if (head_valid) begin
      case (state_reg)
        BEAT_LO: begin
          beat_data = lo_mem[rd_ptr_reg];
          if (head_wide) begin
            beat_addr  = {head_rd[4:1], 1'b0};
            state_next = BEAT_HI;
          end else begin
            beat_addr = head_rd;
            pop       = 1'b1;
          end
        end
        BEAT_HI: begin
          beat_addr  = {head_rd[4:1], 1'b1};
          beat_data  = hi_mem[rd_ptr_reg];
          pop        = 1'b1;
          state_next = BEAT_LO;
        end
        default: state_next = BEAT_LO;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= BEAT_LO;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Entry payload needs no reset: validity is derived from count/pointers.
  always_ff @(posedge clock) begin
    if (push) begin
      wide_mem[wr_ptr_reg] <= req.req_wide;
      rd_mem[wr_ptr_reg]   <= req.req_rd;
      lo_mem[wr_ptr_reg]   <= req.req_wdata_lo;
      hi_mem[wr_ptr_reg]   <= req.req_wdata_hi;
    end
  end

  // Outputs are forced to their reset values while reset is held so that a
  // beat in flight is not written to the regfile at the reset edge.
  assign req.req_ready = reset || !full;
  assign rd_wen        = !reset && head_valid && (beat_addr != 5'd0);
  assign rd_addr       = reset ? 5'd0  : beat_addr;
  assign rd_wdata      = reset ? 32'd0 : beat_data;
  assign idle          = reset || (count_reg == '0);

  // Pending-write scoreboard over all FIFO slots.
  logic [4:0]             rs_addr [3];
  logic [2:0]             rs_busy;
  logic [2:0][DEPTH-1:0]  hit;
  logic [DEPTH-1:0]       lo_pend;
  logic [DEPTH-1:0]       hi_pend;
  logic [4:0]             lo_addr [DEPTH];
  logic [4:0]             hi_addr [DEPTH];

  assign rs_addr[0] = rs1_addr;
  assign rs_addr[1] = rs2_addr;
  assign rs_addr[2] = rs3_addr;

  genvar gi, gj;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [PTR_W-1:0] offset;
      logic             slot_valid;
      logic             is_head;
      // Distance from the head, modulo DEPTH; slots within count are live.
      assign offset     = PTR_W'(gi) - rd_ptr_reg;
      assign slot_valid = (CNT_W'(offset) < count_reg);
      assign is_head    = (offset == '0);
      assign lo_addr[gi] = wide_mem[gi] ? {rd_mem[gi][4:1], 1'b0} : rd_mem[gi];
      assign hi_addr[gi] = {rd_mem[gi][4:1], 1'b1};
      // The head's lo beat has already been written once in BEAT_HI.
      assign lo_pend[gi] = slot_valid && !(is_head && state_reg == BEAT_HI);
      assign hi_pend[gi] = slot_valid && wide_mem[gi];
      for (gj = 0; gj < 3; gj++) begin : g_port
        assign hit[gj][gi] = (lo_pend[gi] && lo_addr[gi] == rs_addr[gj]) ||
                             (hi_pend[gi] && hi_addr[gi] == rs_addr[gj]);
      end
    end
    for (gj = 0; gj < 3; gj++) begin : g_busy
      assign rs_busy[gj] = !reset && (rs_addr[gj] != 5'd0) && (|hit[gj]);
    end
  endgenerate

  assign rs1_busy = rs_busy[0];
  assign rs2_busy = rs_busy[1];
  assign rs3_busy = rs_busy[2];

endmodule

// File: tb/tb_xc_rf_writeback.sv
module tb_xc_rf_writeback;
  localparam int DEPTH = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        rd_wen;
  logic [4:0]  rd_addr;
  logic [31:0] rd_wdata;
  logic [4:0]  rs1_addr, rs2_addr, rs3_addr;
  logic        rs1_busy, rs2_busy, rs3_busy;
  logic        idle;

  xc_rf_writeback_if req_if ();

  xc_rf_writeback #(.DEPTH(DEPTH)) dut (
    .clock    (clock),
    .reset    (reset),
    .req      (req_if),
    .rd_wen   (rd_wen),
    .rd_addr  (rd_addr),
    .rd_wdata (rd_wdata),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs3_addr (rs3_addr),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .rs3_busy (rs3_busy),
    .idle     (idle)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        wide;
    logic [4:0]  rd;
    logic [31:0] lo;
    logic [31:0] hi;
  } ent_t;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  ent_t m_q[$];      // reference FIFO of accepted requests
  bit   m_hi = 1'b0; // reference: head lo beat already written
  wr_t  sb[$];       // expected regfile writes, in order

  int checks = 0;
  int passes = 0;
  int wen_run = 0;
  int max_run = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model helpers ----------------
  function automatic logic [4:0] m_addr();
    if (m_q.size() == 0) return 5'd0;
    if (m_hi) return {m_q[0].rd[4:1], 1'b1};
    if (m_q[0].wide) return {m_q[0].rd[4:1], 1'b0};
    return m_q[0].rd;
  endfunction

  function automatic logic [31:0] m_data();
    if (m_q.size() == 0) return 32'd0;
    return m_hi ? m_q[0].hi : m_q[0].lo;
  endfunction

  function automatic logic m_busy(input logic [4:0] a);
    logic [4:0] lo_a;
    if (a == 5'd0) return 1'b0;
    foreach (m_q[k]) begin
      lo_a = m_q[k].wide ? {m_q[k].rd[4:1], 1'b0} : m_q[k].rd;
      if (!(k == 0 && m_hi) && lo_a == a) return 1'b1;
      if (m_q[k].wide && {m_q[k].rd[4:1], 1'b1} == a) return 1'b1;
    end
    return 1'b0;
  endfunction

  // ---------------- monitor: retire writes against scoreboard ----------------
  always @(negedge clock) begin
    wr_t exp_w;
    if (rd_wen === 1'b1) begin
      wen_run++;
      if (wen_run > max_run) max_run = wen_run;
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL write_unexpected: got addr %0d data %h, required no write (t=%0t)",
                 rd_addr, rd_wdata, $time);
      end else begin
        exp_w = sb.pop_front();
        chk("write_addr", {27'd0, rd_addr}, {27'd0, exp_w.a});
        chk("write_data", rd_wdata, exp_w.d);
      end
    end else begin
      wen_run = 0;
    end
  end

  // ---------------- stimulus: one cycle per call, entered at posedge+1 -------
  task automatic step(input logic v, input logic w, input logic [4:0] rd,
                      input logic [31:0] lo, input logic [31:0] hi,
                      input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3,
                      output logic acc);
    ent_t e;
    logic [4:0] ea;
    req_if.req_valid    = v;
    req_if.req_wide     = w;
    req_if.req_rd       = rd;
    req_if.req_wdata_lo = lo;
    req_if.req_wdata_hi = hi;
    rs1_addr = a1;
    rs2_addr = a2;
    rs3_addr = a3;
    #1;
    ea = m_addr();
    chk("req_ready", req_if.req_ready, m_q.size() < DEPTH);
    chk("rd_wen", rd_wen, (m_q.size() != 0) && (ea != 5'd0));
    chk("rd_addr", {27'd0, rd_addr}, {27'd0, ea});
    chk("rd_wdata", rd_wdata, m_data());
    chk("rs1_busy", rs1_busy, m_busy(a1));
    chk("rs2_busy", rs2_busy, m_busy(a2));
    chk("rs3_busy", rs3_busy, m_busy(a3));
    chk("idle", idle, m_q.size() == 0);
    acc = v && (m_q.size() < DEPTH);
    @(posedge clock);
    if (m_q.size() != 0) begin
      if (m_hi) begin
        m_q.delete(0);
        m_hi = 1'b0;
      end else if (m_q[0].wide) begin
        m_hi = 1'b1;
      end else begin
        m_q.delete(0);
      end
    end
    if (acc) begin
      e.wide = w; e.rd = rd; e.lo = lo; e.hi = hi;
      m_q.push_back(e);
      if (w) begin
        if ({rd[4:1], 1'b0} != 5'd0) sb.push_back({rd[4:1], 1'b0, lo});
        sb.push_back({rd[4:1], 1'b1, hi});
      end else if (rd != 5'd0) begin
        sb.push_back({rd, lo});
      end
    end
    #1;
  endtask

  task automatic idle_step(input logic [4:0] a1, input logic [4:0] a2);
    logic acc;
    step(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, a1, a2, 5'd0, acc);
  endtask

  // One reset cycle, entered at posedge+1; pending entries are discarded.
  task automatic reset_cycle(input logic [4:0] a1, input logic [4:0] a2);
    reset = 1'b1;
    req_if.req_valid = 1'b0;
    rs1_addr = a1;
    rs2_addr = a2;
    m_q.delete();
    m_hi = 1'b0;
    sb.delete();
    #1;
    chk("rst_ready", req_if.req_ready, 1);
    chk("rst_wen", rd_wen, 0);
    chk("rst_addr", {27'd0, rd_addr}, 0);
    chk("rst_wdata", rd_wdata, 0);
    chk("rst_busy1", rs1_busy, 0);
    chk("rst_busy2", rs2_busy, 0);
    chk("rst_idle", idle, 1);
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk("post_rst_ready", req_if.req_ready, 1);
    chk("post_rst_wen", rd_wen, 0);
    chk("post_rst_idle", idle, 1);
  endtask

  logic [4:0]  burst_rd [3];
  logic [31:0] burst_lo [3];

  initial begin
    logic acc;
    int   n;
    int   guard;
    reset = 1'b1;
    req_if.req_valid = 1'b0;
    req_if.req_wide = 1'b0;
    req_if.req_rd = 5'd0;
    req_if.req_wdata_lo = 32'd0;
    req_if.req_wdata_hi = 32'd0;
    rs1_addr = 5'd0; rs2_addr = 5'd0; rs3_addr = 5'd0;
    @(posedge clock);
    #1;
    reset_cycle(5'd5, 5'd6);

    // Narrow write to x5.
    step(1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 32'h0, 5'd5, 5'd0, 5'd0, acc);
    chk("t1_wen", rd_wen, 1);
    chk("t1_addr", {27'd0, rd_addr}, 5);
    chk("t1_data", rd_wdata, 32'hDEADBEEF);
    chk("t1_busy", rs1_busy, 1);
    idle_step(5'd5, 5'd0);
    chk("t1_idle", idle, 1);
    chk("t1_busy_clr", rs1_busy, 0);

    // Wide write to pair 6/7.
    step(1'b1, 1'b1, 5'd7, 32'h11111111, 32'h22222222, 5'd0, 5'd6, 5'd0, acc);
    chk("t2_lo_addr", {27'd0, rd_addr}, 6);
    chk("t2_lo_data", rd_wdata, 32'h11111111);
    chk("t2_busy6", rs2_busy, 1);
    idle_step(5'd0, 5'd6);
    chk("t2_hi_addr", {27'd0, rd_addr}, 7);
    chk("t2_hi_data", rd_wdata, 32'h22222222);
    chk("t2_busy6_clr", rs2_busy, 0);
    idle_step(5'd0, 5'd7);
    chk("t2_busy7_clr", rs2_busy, 0);
    chk("t2_idle", idle, 1);

    // Three back-to-back wide requests into a 2-entry FIFO.
    burst_rd[0] = 5'd2;  burst_lo[0] = 32'hA0A0A0A0;
    burst_rd[1] = 5'd4;  burst_lo[1] = 32'hB0B0B0B0;
    burst_rd[2] = 5'd9;  burst_lo[2] = 32'hC0C0C0C0;
    max_run = 0;
    n = 0;
    guard = 0;
    while (n < 3 && guard < 20) begin
      step(1'b1, 1'b1, burst_rd[n], burst_lo[n], ~burst_lo[n], 5'd3, 5'd8, 5'd9, acc);
      if (acc) begin
        n++;
        if (n == 2) chk("t3_full_ready", req_if.req_ready, 0);
      end
      guard++;
    end
    chk("t3_accepted", n, 3);
    for (int i = 0; i < 6; i++) idle_step(5'd3, 5'd8);
    chk("t3_run", max_run, 6);

    // Write to x0 consumes a beat without enabling the write port.
    step(1'b1, 1'b0, 5'd0, 32'hFFFFFFFF, 32'h0, 5'd0, 5'd1, 5'd0, acc);
    chk("t4_x0_wen", rd_wen, 0);
    chk("t4_x0_busy", rs1_busy, 0);
    step(1'b1, 1'b0, 5'd1, 32'h5, 32'h0, 5'd0, 5'd1, 5'd0, acc);
    chk("t4_wen", rd_wen, 1);
    chk("t4_addr", {27'd0, rd_addr}, 1);
    chk("t4_busy0", rs1_busy, 0);
    idle_step(5'd0, 5'd1);

    // Reset while a pair write is in its hi beat.
    step(1'b1, 1'b1, 5'd10, 32'hAAAA0000, 32'hBBBB0000, 5'd10, 5'd11, 5'd0, acc);
    chk("t5_lo_addr", {27'd0, rd_addr}, 10);
    idle_step(5'd10, 5'd11);
    chk("t5_hi_addr", {27'd0, rd_addr}, 11);
    reset_cycle(5'd10, 5'd11);
    step(1'b1, 1'b0, 5'd3, 32'h33, 32'h0, 5'd3, 5'd11, 5'd0, acc);
    chk("t5_after_addr", {27'd0, rd_addr}, 3);
    chk("t5_after_data", rd_wdata, 32'h33);
    idle_step(5'd3, 5'd11);

    // Random traffic against the reference model.
    for (int i = 0; i < 10000; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 7)), $urandom(), $urandom(),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), acc);
    end
    for (int i = 0; i < 8; i++) idle_step(5'd0, 5'd0);
    chk("sb_drained", sb.size(), 0);
    chk("final_idle", idle, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/xc_rf_writeback.md
Name: xc_rf_writeback

Overview:
Write-side front end for the 3-read-1-write GPR file. It accepts 32-bit (narrow) and 64-bit (wide, register-pair) results from the execute stage over a valid/ready handshake and buffers them in a small FIFO. It serialises them onto the single regfile write port, one register per cycle. It also reports, per read port, whether a buffered write to the addressed register is still pending, so issue logic can stall.

Parameters:
DEPTH, 2, FIFO entries; power of two, minimum 2.

Ports:
clock  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  result request valid
req_ready  out  1  FIFO can accept a request
req_wide  in  1  1 = 64-bit pair write, 0 = single 32-bit write
req_rd  in  5  destination register
req_wdata_lo  in  32  data for narrow write, or even register of pair
req_wdata_hi  in  32  data for odd register of pair; ignored when req_wide=0
rd_wen  out  1  regfile write enable
rd_addr  out  5  regfile write address
rd_wdata  out  32  regfile write data
rs1_addr  in  5  read address of port 1
rs2_addr  in  5  read address of port 2
rs3_addr  in  5  read address of port 3
rs1_busy  out  1  pending buffered write to rs1_addr
rs2_busy  out  1  pending buffered write to rs2_addr
rs3_busy  out  1  pending buffered write to rs3_addr
idle  out  1  FIFO empty and no beat in progress

Behaviour:
- Handshake: a transfer occurs on a rising edge with req_valid && req_ready. req_ready = !full. req_ready does not depend on req_valid. There is no same-cycle bypass: when full, req_ready=0 even if the head pops this cycle.
- Stored per entry: wide, rd, lo, hi. For a wide entry, the lo address is {rd[4:1],1'b0} and the hi address is {rd[4:1],1'b1}; req_rd[0] is ignored.
- Beat FSM on the FIFO head, states BEAT_LO and BEAT_HI. Reset state is BEAT_LO.
  - BEAT_LO with head valid, narrow: write rd/lo, pop the entry, stay in BEAT_LO.
  - BEAT_LO with head valid, wide: write the lo address with lo data, go to BEAT_HI, no pop.
  - BEAT_HI: write the hi address with hi data, pop the entry, return to BEAT_LO.
- The write port is combinational from the head and the FSM state.
  - rd_wen = head valid && beat address != 0.
  - rd_addr and rd_wdata are 0 when the head is empty.
  - A beat addressed to x0 still consumes its cycle, with rd_wen=0.
- Latency: a request accepted at edge N drives rd_wen during the cycle after N, and the regfile updates at edge N+1. A wide request's hi beat follows one cycle later. Sustained throughput is one register per cycle.
- Simultaneous push and pop when not full: both happen, and occupancy is unchanged.
- Pointers wrap modulo DEPTH. A separate count, 0..DEPTH, distinguishes full from empty.
- rsX_busy = rsX_addr != 0 and it matches any pending beat address:
  - every address of every valid non-head entry, both addresses for wide entries;
  - for the head, only beats not yet written, i.e. the lo address is dropped once in BEAT_HI.
  - The beat being presented this cycle counts as pending.
- idle = (count == 0). In BEAT_HI the count is at least 1, so idle is 0.
- Reset, including mid-operation: count, pointers and FSM cleared, all entries invalid.
  - Output values during and after reset: req_ready=1, rd_wen=0, rd_addr=0, rd_wdata=0, all busy=0, idle=1.
  - Entries pending at reset are discarded and never written.
- No ordering changes: writes retire in acceptance order. A later write to the same register overwrites the earlier one.

Test Plan:
- Reset, then narrow {rd=5, lo=0xDEADBEEF} accepted at edge 1 -> cycle after edge 1: rd_wen=1, rd_addr=5, rd_wdata=0xDEADBEEF, rs1_busy=1 for rs1_addr=5; after edge 2: idle=1 and rs1_busy=0.
- Wide {rd=7, lo=0x11111111, hi=0x22222222} -> beat 1: addr 6, data 0x11111111; beat 2: addr 7, data 0x22222222; rs2_busy for addr 6 drops after beat 1, for addr 7 after beat 2.
- Push 3 wide requests back-to-back with DEPTH=2 -> req_ready=0 while count=2; the third is accepted only after the first entry pops; output shows 6 consecutive rd_wen cycles with addresses in order.
- Narrow {rd=0, lo=0xFFFFFFFF} followed by narrow {rd=1, lo=0x5} -> cycle 1: rd_wen=0; cycle 2: rd_wen=1, rd_addr=1; rs1_busy stays 0 for rs1_addr=0 throughout.
- Wide request to rd=10, reset asserted during BEAT_HI -> no write to register 11, rd_wen=0 in the reset cycle, idle=1 and req_ready=1 after it; a new narrow write then retires normally.
- Continuous random valid traffic for 10k cycles against a reference queue model -> write sequence, busy flags and req_ready match the model every cycle.
